// File: rtl/genie_pipe_chain.sv
// Elastic valid/ready pipeline of STAGES register slices, each either forward-registered
// (SKID=0) or a two-entry skid slice with registered ready (SKID=1), plus flush and occupancy.
module genie_pipe_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = $clog2(2*STAGES+1)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_count
);

    if (STAGES < 1) begin : g_stages_chk
        $error("genie_pipe_chain: STAGES must be >= 1");
    end
    if (WIDTH < 1) begin : g_width_chk
        $error("genie_pipe_chain: WIDTH must be >= 1");
    end

    logic [STAGES-1:0] main_vld;
    logic [STAGES-1:0] skid_vld;
    logic [WIDTH-1:0]  main_dat [STAGES];
    logic [WIDTH-1:0]  skid_dat [STAGES];
    logic [STAGES-1:0] up_vld;
    logic [WIDTH-1:0]  up_dat   [STAGES];
    logic [STAGES-1:0] in_fire;
    logic [STAGES-1:0] main_free;
    logic              up_fire;
    logic              dn_fire;

    // slice i is fed by slice i-1's main register; slice 0 by the upstream port
    always_comb begin
        up_vld[0] = i_valid;
        up_dat[0] = i_data;
        for (int i = 1; i < STAGES; i++) begin
            up_vld[i] = main_vld[i-1];
            up_dat[i] = main_dat[i-1];
        end
    end

    // Ready walks from the sink back to the source. In skid mode each slice's
    // up-ready is just !skid_vld, which breaks the path from i_ready to o_ready.
    always_comb begin : ready_chain
        logic r;
        r         = i_ready;
        main_free = '0;
        in_fire   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            main_free[i] = !main_vld[i] || r;
            if (SKID != 0) begin
                r = !skid_vld[i];
            end else begin
                r = main_free[i];
            end
            in_fire[i] = up_vld[i] && r;
        end
        o_ready = r;
    end

    // When main frees up, a held skid entry takes priority; skid-ready is low then,
    // so no new beat can arrive in that same edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            main_vld <= '0;
            skid_vld <= '0;
        end else if (i_flush) begin
            main_vld <= '0;
            skid_vld <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (main_free[i]) begin
                    main_vld[i] <= skid_vld[i] || in_fire[i];
                    skid_vld[i] <= 1'b0;
                end else if (in_fire[i]) begin
                    skid_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (main_free[i]) begin
                main_dat[i] <= skid_vld[i] ? skid_dat[i] : up_dat[i];
            end else if (in_fire[i]) begin
                skid_dat[i] <= up_dat[i];
            end
        end
    end

    // occupancy tracks port transfers; a flush-cycle upstream beat is never counted
    assign up_fire = i_valid && o_ready;
    assign dn_fire = main_vld[STAGES-1] && i_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_count <= '0;
        end else if (i_flush) begin
            o_count <= '0;
        end else if (up_fire && !dn_fire) begin
            o_count <= o_count + CNT_W'(1);
        end else if (!up_fire && dn_fire) begin
            o_count <= o_count - CNT_W'(1);
        end
    end

    assign o_valid = main_vld[STAGES-1];
    assign o_data  = main_dat[STAGES-1];

endmodule

// File: tb/tb_genie_pipe_chain.sv
// Bench for genie_pipe_chain: seven configurations share one stimulus bus; each task
// selects one instance and checks it against a queue-based reference of the stream.
module tb_genie_pipe_chain;

    function automatic int st_of(input int g);
        case (g)
            0:       return 3;
            1, 2:    return 2;
            3, 4:    return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int sk_of(input int g);
        case (g)
            0, 1, 4, 6: return 1;
            default:    return 0;
        endcase
    endfunction

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic [2:0] sel;

    wire  [6:0] rdy_a;
    wire  [6:0] vld_a;
    wire  [7:0] dat_a [7];
    wire  [7:0] cnt_a [7];

    for (genvar g = 0; g < 7; g++) begin : g_dut
        localparam int ST = st_of(g);
        localparam int SK = sk_of(g);
        localparam int CW = $clog2(2*ST+1);
        logic [CW-1:0] cnt;
        genie_pipe_chain #(.WIDTH(8), .STAGES(ST), .SKID(SK)) u_dut (
            .i_clk    (clk),
            .i_reset_n(rst_n),
            .i_flush  (flush),
            .i_data   (data),
            .i_valid  (valid),
            .o_ready  (rdy_a[g]),
            .o_data   (dat_a[g]),
            .o_valid  (vld_a[g]),
            .i_ready  (ready),
            .o_count  (cnt)
        );
        assign cnt_a[g] = 8'(cnt);
    end

    logic       cur_ready, cur_valid;
    logic [7:0] cur_data, cur_count;
    assign cur_ready = rdy_a[sel];
    assign cur_valid = vld_a[sel];
    assign cur_data  = dat_a[sel];
    assign cur_count = cnt_a[sel];

    logic       s_ready, s_valid, s_up, s_dn;
    logic [7:0] s_data, s_count;
    logic [7:0] q [$];
    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // sample just before the edge, then return #1 after it so callers can drive
    task automatic tick();
        @(negedge clk);
        s_ready = cur_ready;
        s_valid = cur_valid;
        s_data  = cur_data;
        s_count = cur_count;
        s_up    = valid && cur_ready;
        s_dn    = cur_valid && ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        valid = 1'b0;
        ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        ready = 1'b0;
        flush = 1'b0;
        #2;
        for (int i = 0; i < 7; i++) begin
            sel = 3'(i);
            #1;
            n_tests++;
            if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", i, cur_valid); end
            n_tests++;
            if (cur_count !== 8'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d want 0", i, cur_count); end
            n_tests++;
            if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", i, cur_ready); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int acc_b, del_b;
        logic exp_v;
        sel = 3'd0;
        do_reset();
        ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            valid = (c < 8);
            data  = 8'(c + 1);
            tick();
            acc_b = (c < 8) ? c : 8;
            del_b = (c < 3) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
            exp_v = (c >= 3) && (c < 11);
            n_tests++;
            if (s_up !== (c < 8)) begin n_fail++; $display("FAIL lat_accept c=%0d: got %b want %b", c, s_up, (c < 8)); end
            n_tests++;
            if (s_valid !== exp_v) begin n_fail++; $display("FAIL lat_valid c=%0d: got %b want %b", c, s_valid, exp_v); end
            if (exp_v) begin
                n_tests++;
                if (s_data !== 8'(c - 2)) begin n_fail++; $display("FAIL lat_data c=%0d: got %0h want %0h", c, s_data, 8'(c - 2)); end
            end
            n_tests++;
            if (s_count !== 8'(acc_b - del_b)) begin n_fail++; $display("FAIL lat_count c=%0d: got %0d want %0d", c, s_count, acc_b - del_b); end
        end
        valid = 1'b0;
    endtask

    task automatic test_fill_stall();
        int acc = 0;
        sel = 3'd1;
        do_reset();
        ready = 1'b0;
        valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            data = 8'(16 + acc);
            tick();
            if (s_up) acc++;
        end
        n_tests++;
        if (acc != 4) begin n_fail++; $display("FAIL fill_accepted: got %0d want 4", acc); end
        n_tests++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", s_ready); end
        n_tests++;
        if (s_count !== 8'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", s_count); end
        n_tests++;
        if (s_valid !== 1'b1 || s_data !== 8'h10) begin n_fail++; $display("FAIL fill_head: got v=%b d=%0h want v=1 d=10", s_valid, s_data); end
        valid = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (s_valid !== (c < 4)) begin n_fail++; $display("FAIL drain_valid c=%0d: got %b want %b", c, s_valid, (c < 4)); end
            if (c < 4) begin
                n_tests++;
                if (s_data !== 8'(16 + c)) begin n_fail++; $display("FAIL drain_data c=%0d: got %0h want %0h", c, s_data, 8'(16 + c)); end
            end
            n_tests++;
            if (s_count !== 8'(4 - c)) begin n_fail++; $display("FAIL drain_count c=%0d: got %0d want %0d", c, s_count, 4 - c); end
        end
    endtask

    task automatic test_comb_mode();
        int acc = 0;
        int del = 0;
        logic [7:0] exp;
        sel = 3'd2;
        do_reset();
        ready = 1'b0;
        valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            data = 8'(64 + acc);
            tick();
            if (s_up) begin q.push_back(data); acc++; end
        end
        n_tests++;
        if (acc != 2) begin n_fail++; $display("FAIL comb_accepted: got %0d want 2", acc); end
        #1;
        n_tests++;
        if (cur_ready !== 1'b0) begin n_fail++; $display("FAIL comb_ready_low: got %b want 0", cur_ready); end
        ready = 1'b1;
        #1;
        n_tests++;
        if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL comb_ready_follow: got %b want 1", cur_ready); end
        ready = 1'b0;
        #1;
        for (int c = 0; c < 200 && (acc < 22 || q.size() > 0); c++) begin
            valid = (acc < 22);
            data  = 8'(64 + acc);
            ready = ~ready;
            tick();
            if (s_dn) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL comb_dup: got %0h want nothing", s_data);
                end else begin
                    exp = q.pop_front();
                    if (s_data !== exp) begin n_fail++; $display("FAIL comb_order: got %0h want %0h", s_data, exp); end
                end
                del++;
            end
            if (s_up) begin q.push_back(data); acc++; end
        end
        n_tests++;
        if (acc != 22 || del != 22 || q.size() != 0) begin
            n_fail++; $display("FAIL comb_total: got acc=%0d del=%0d left=%0d want 22 22 0", acc, del, q.size());
        end
        valid = 1'b0;
    endtask

    task automatic test_random(input int which);
        int del = 0;
        int cap;
        logic [7:0] exp;
        sel = 3'(which);
        cap = (sk_of(which) != 0) ? 2 * st_of(which) : st_of(which);
        do_reset();
        for (int c = 0; c < 12000 && del < 1000; c++) begin
            valid = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            ready = 1'($urandom_range(0, 1));
            tick();
            n_tests++;
            if (int'(s_count) != q.size()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", which, s_count, q.size()); end
            if (q.size() == 0) begin
                n_tests++;
                if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_empty_valid[%0d]: got %b want 0", which, s_valid); end
            end
            if (s_dn) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_dup[%0d]: got %0h want nothing", which, s_data);
                end else begin
                    exp = q.pop_front();
                    if (s_data !== exp) begin n_fail++; $display("FAIL rnd_order[%0d]: got %0h want %0h", which, s_data, exp); end
                end
                del++;
            end
            if (s_up) q.push_back(data);
            n_tests++;
            if (q.size() > cap) begin n_fail++; $display("FAIL rnd_capacity[%0d]: got %0d want <= %0d", which, q.size(), cap); end
        end
        n_tests++;
        if (del < 1000) begin n_fail++; $display("FAIL rnd_timeout[%0d]: got %0d beats want 1000", which, del); end
        valid = 1'b0;
    endtask

    task automatic test_flush(input int which);
        int st;
        sel = 3'(which);
        st  = st_of(which);
        do_reset();
        ready = 1'b0;
        valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            data = 8'(48 + n);
            tick();
        end
        valid = 1'b0;
        tick();
        n_tests++;
        if (s_count !== 8'd3) begin n_fail++; $display("FAIL flush_pre_count[%0d]: got %0d want 3", which, s_count); end
        flush = 1'b1;
        valid = 1'b1;
        data  = 8'h55;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        tick();
        n_tests++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid[%0d]: got %b want 0", which, s_valid); end
        n_tests++;
        if (s_count !== 8'd0) begin n_fail++; $display("FAIL flush_count[%0d]: got %0d want 0", which, s_count); end
        n_tests++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready[%0d]: got %b want 1", which, s_ready); end
        ready = 1'b1;
        valid = 1'b1;
        data  = 8'hAA;
        tick();
        valid = 1'b0;
        for (int c = 1; c <= st + 3; c++) begin
            tick();
            n_tests++;
            if (s_valid !== (c == st)) begin n_fail++; $display("FAIL flush_after_valid[%0d] c=%0d: got %b want %b", which, c, s_valid, (c == st)); end
            if (s_valid) begin
                n_tests++;
                if (s_data !== 8'hAA) begin n_fail++; $display("FAIL flush_after_data[%0d]: got %0h want aa", which, s_data); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp;
        sel = 3'd6;
        do_reset();
        ready = 1'b0;
        valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            data = 8'($urandom);
            tick();
        end
        n_tests++;
        if (s_count !== 8'd8) begin n_fail++; $display("FAIL areset_full: got %0d want 8", s_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", cur_valid); end
        n_tests++;
        if (cur_count !== 8'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", cur_count); end
        n_tests++;
        if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", cur_ready); end
        valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        q.delete();
        ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            valid = (c < 5);
            data  = 8'($urandom);
            tick();
            n_tests++;
            if (s_valid !== (c >= 4 && c < 9)) begin n_fail++; $display("FAIL areset_resume_valid c=%0d: got %b want %b", c, s_valid, (c >= 4 && c < 9)); end
            if (s_dn && q.size() > 0) begin
                exp = q.pop_front();
                n_tests++;
                if (s_data !== exp) begin n_fail++; $display("FAIL areset_resume_data: got %0h want %0h", s_data, exp); end
            end
            if (s_up) q.push_back(data);
        end
        n_tests++;
        if (q.size() != 0) begin n_fail++; $display("FAIL areset_resume_left: got %0d want 0", q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        valid = 1'b0;
        ready = 1'b0;
        data  = 8'd0;
        sel   = 3'd0;
        @(posedge clk); #1;
        test_reset();
        test_latency();
        test_fill_stall();
        test_comb_mode();
        test_random(3);
        test_random(4);
        test_random(5);
        test_random(6);
        test_flush(0);
        test_flush(5);
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
